// File: rtl/inter.sv
// inter: fixed-latency capture pipeline of DEPTH stages, with a sticky q_valid once all stages hold post-reset data.
// Optional registered even parity output q_par is built only when INTER_PARITY_EN is defined.
module inter #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid
`ifdef INTER_PARITY_EN
  ,
  output logic             q_par
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [CW-1:0]    fill;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign Q = stage[DEPTH-1];

  // q_valid rises on the same edge the counter reaches DEPTH, so it lines up with the first real sample on Q.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fill    <= '0;
      q_valid <= 1'b0;
    end else begin
      if (fill != FULL) fill <= fill + CW'(1);
      if (fill >= LAST) q_valid <= 1'b1;
    end
  end

`ifdef INTER_PARITY_EN
  logic [WIDTH-1:0] last_in;

  if (DEPTH == 1) begin : g_par_d
    assign last_in = d;
  end else begin : g_par_stage
    assign last_in = stage[DEPTH-2];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) q_par <= 1'b0;
    else       q_par <= ^last_in;
  end
`endif

endmodule

// File: tb/tb_inter.sv
// tb_inter: scoreboard bench for inter, using a single-stage 1-bit instance and a three-stage 8-bit instance.
// Optional parity checks are compiled only when INTER_PARITY_EN is defined.
module tb_inter;

  logic       clk = 1'b0;
  logic       rst1, d1, q1, v1;
  logic       rst3, v3;
  logic [7:0] d3, q3;
`ifdef INTER_PARITY_EN
  logic       par1, par3;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] sb3 [$];
  int         edges3;

  always #5 clk = ~clk;

  inter #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst1), .d(d1), .Q(q1), .q_valid(v1)
`ifdef INTER_PARITY_EN
    , .q_par(par1)
`endif
  );

  inter #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst3), .d(d3), .Q(q3), .q_valid(v3)
`ifdef INTER_PARITY_EN
    , .q_par(par3)
`endif
  );

  task automatic reset3();
    @(negedge clk);
    rst3 = 1'b1;
    sb3.delete();
    repeat (2) sb3.push_back(8'h00);
    edges3 = 0;
    @(negedge clk);
    rst3 = 1'b0;
  endtask

  task automatic cycle3(input logic [7:0] v);
    logic [7:0] exp;
    logic       exp_v;
    d3 = v;
    sb3.push_back(v);
    @(posedge clk);
    #1;
    exp = sb3.pop_front();
    edges3++;
    exp_v = (edges3 >= 3);
    total++;
    if (q3 !== exp) begin
      bad++;
      $display("[TB] FAIL pipe_q edge=%0d got=%h want=%h", edges3, q3, exp);
    end
    total++;
    if (v3 !== exp_v) begin
      bad++;
      $display("[TB] FAIL pipe_valid edge=%0d got=%b want=%b", edges3, v3, exp_v);
    end
`ifdef INTER_PARITY_EN
    total++;
    if (par3 !== ^exp) begin
      bad++;
      $display("[TB] FAIL pipe_par edge=%0d got=%b want=%b", edges3, par3, ^exp);
    end
`endif
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1; d1 = 1'b1; d3 = 8'hFF;
    repeat (2) begin
      @(posedge clk);
      #1;
      total++;
      if (q1 !== 1'b0 || v1 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_dut1 got q=%b v=%b want q=0 v=0", q1, v1);
      end
      total++;
      if (q3 !== 8'h00 || v3 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_dut3 got q=%h v=%b want q=00 v=0", q3, v3);
      end
`ifdef INTER_PARITY_EN
      total++;
      if (par1 !== 1'b0 || par3 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_par got %b/%b want 0/0", par1, par3);
      end
`endif
    end
  endtask

  task automatic test_single_stage();
    @(negedge clk);
    rst1 = 1'b0;
    d1   = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b1 || v1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_first got q=%b v=%b want q=1 v=1", q1, v1);
    end
    d1 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b0 || v1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_second got q=%b v=%b want q=0 v=1", q1, v1);
    end
  endtask

  task automatic test_async_reset();
    d1 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_pre got q=%b want 1", q1);
    end
    #2;
    rst1 = 1'b1;
    #1;
    total++;
    if (q1 !== 1'b0 || v1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_clear got q=%b v=%b want q=0 v=0", q1, v1);
    end
  endtask

  task automatic test_pipeline();
    reset3();
    cycle3(8'hA5);
    cycle3(8'h3C);
    cycle3(8'hFF);
    cycle3(8'h00);
    cycle3(8'h00);
  endtask

  task automatic test_midflight_reset();
    cycle3(8'h11);
    cycle3(8'h22);
    cycle3(8'h33);
    #2;
    rst3 = 1'b1;
    #1;
    total++;
    if (q3 !== 8'h00 || v3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midflight_clear got q=%h v=%b want q=00 v=0", q3, v3);
    end
    reset3();
    cycle3(8'h5A);
    cycle3(8'h6B);
    cycle3(8'h7C);
  endtask

  task automatic test_parity();
`ifdef INTER_PARITY_EN
    reset3();
    cycle3(8'h07);
    cycle3(8'h03);
    cycle3(8'h03);
    total++;
    if (q3 !== 8'h07 || par3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL parity_07 got q=%h par=%b want q=07 par=1", q3, par3);
    end
    cycle3(8'h03);
    total++;
    if (q3 !== 8'h03 || par3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL parity_03 got q=%h par=%b want q=03 par=0", q3, par3);
    end
`endif
  endtask

  task automatic test_back_to_back();
    reset3();
    for (int i = 0; i < 24; i++) cycle3(8'($urandom_range(0, 255)));
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_async_reset();
    test_pipeline();
    test_midflight_reset();
    test_parity();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
